// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: nibble-store driven multi-digit 7-segment controller with blink, zero blanking and scroll
//   clk, rst_n                        : clock, asynchronous active-low reset
//   wr_en, wr_addr, wr_data           : single nibble write; out-of-range addresses are ignored
//   load_valid, load_ready, load_data : bulk load of every nibble, held off while wr_en is high
//   mode, blink_mask                  : 0 hex, 1 zero-blanked hex, 2 scroll, 3 blank; per-digit blink enable
//   seg                               : registered active-low segments {g,f,e,d,c,b,a} per digit
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_PERIOD = 25_000_000,
  parameter int SCROLL_PERIOD = 50_000_000,
  localparam int AW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [3:0]                wr_data,
  input  logic                      load_valid,
  input  logic [4*NUM_DIGITS-1:0]   load_data,
  output logic                      load_ready,
  input  logic [1:0]                mode,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  output logic [7*NUM_DIGITS-1:0]   seg
);
  localparam int BW = $clog2(BLINK_PERIOD);
  localparam int SW = $clog2(SCROLL_PERIOD);
  localparam logic [15:0][6:0] seg_lut = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  logic [4*NUM_DIGITS-1:0] nib;
  logic [1:0] mode_r;
  logic [NUM_DIGITS-1:0] mask_r;
  logic [BW-1:0] bcnt;
  logic phase;
  logic [SW-1:0] scnt;
  logic [AW-1:0] off;
  logic [7*NUM_DIGITS-1:0] seg_n;
  logic load_go, bwrap, swrap;
  assign load_ready = rst_n & ~wr_en;
  assign load_go = load_valid & load_ready;
  assign bwrap = bcnt == BW'(BLINK_PERIOD - 1);
  assign swrap = scnt == SW'(SCROLL_PERIOD - 1);
  // mode and blink_mask are registered alongside the nibbles so every source reaches seg with the same latency
  always_comb begin
    int top, s;
    top = 0;
    seg_n = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (nib[4*i+:4] != 4'h0) top = i;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      s = i + int'(off);
      s = s >= NUM_DIGITS ? s - NUM_DIGITS : s;
      seg_n[7*i+:7] = (mask_r[i] && phase) || mode_r == 2'd3 || (mode_r == 2'd1 && i > top)
                      ? 7'h7F : seg_lut[mode_r == 2'd2 ? nib[4*s+:4] : nib[4*i+:4]];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      nib <= '0;
      mode_r <= '0;
      mask_r <= '0;
      bcnt <= '0;
      phase <= 1'b0;
      scnt <= '0;
      off <= '0;
      seg <= '1;
    end else begin
      mode_r <= mode;
      mask_r <= blink_mask;
      seg <= seg_n;
      bcnt <= bwrap ? '0 : bcnt + 1'b1;
      phase <= phase ^ bwrap;
      scnt <= mode != 2'd2 || swrap ? '0 : scnt + 1'b1;
      off <= mode != 2'd2 || load_go ? '0 : !swrap ? off : off == AW'(NUM_DIGITS - 1) ? '0 : off + 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++)
        if (wr_en ? wr_addr == AW'(i) : load_valid)
          nib[4*i+:4] <= wr_en ? wr_data : load_data[4*i+:4];
    end
endmodule
